// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared definitions for the PLL lock supervisor.
//   - pll_sup_state_e : supervisor FSM states
//   - PLL_SEL_W       : width of the rPLL IDSEL/FBDSEL/ODSEL buses
//   - cnt_width()     : width of the shared phase counter
package pll_sup_pkg;

   localparam int unsigned PLL_SEL_W = 6;

   typedef enum logic [2:0] {
      RST_HOLD,
      WAIT_LOCK,
      STABLE,
      LOCKED,
      FAULT
   } pll_sup_state_e;

   // One counter serves every timed phase, so it is sized for the longest.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer with synchronous active-low clear.
// Ports:
//   clk   in  destination clock
//   clr_n in  synchronous clear, active low (both flops go to 0)
//   d     in  asynchronous input bit
//   q     out synchronized bit, two clk cycles behind d
module sync_2ff (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences a Gowin rPLL (reset pulse, lock wait with
// timeout, lock qualification, lock-loss recovery, bounded retries) and drives
// its dynamic divider selects from a valid/ready config port.
// Ports:
//   clkin                 in  free-running reference clock (rising edge)
//   rst_n                 in  synchronous reset, active low
//   pll_lock              in  raw PLL LOCK (asynchronous, synchronized here)
//   pll_reset             out PLL RESET, active high
//   pll_idsel/fbdsel/odsel out divider selects to the PLL
//   cfg_valid             in  new divider set requested
//   cfg_idsel/fbdsel/odsel in  requested selects (passed through raw)
//   cfg_ready             out config accepted when cfg_valid & cfg_ready
//   clk_ok                out PLL locked and qualified
//   user_rst_n            out downstream reset, clk_ok delayed one cycle
//   fault                 out retries exhausted
//   retry_cnt             out failed attempts since last lock / accepted config
//   loss_cnt              out lock-loss events, saturating (only when
//                             PLL_SUP_LOSS_CNT_EN is defined)
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned           RST_CYCLES    = 16,
   parameter int unsigned           LOCK_TIMEOUT  = 100000,
   parameter int unsigned           STABLE_CYCLES = 1024,
   parameter int unsigned           MAX_RETRIES   = 3,
   parameter logic [PLL_SEL_W-1:0]  DFLT_IDSEL    = 6'd0,
   parameter logic [PLL_SEL_W-1:0]  DFLT_FBDSEL   = 6'd0,
   parameter logic [PLL_SEL_W-1:0]  DFLT_ODSEL    = 6'd0
) (
   input  logic                                 clkin,
   input  logic                                 rst_n,
   input  logic                                 pll_lock,
   output logic                                 pll_reset,
   output logic [PLL_SEL_W-1:0]                 pll_idsel,
   output logic [PLL_SEL_W-1:0]                 pll_fbdsel,
   output logic [PLL_SEL_W-1:0]                 pll_odsel,
   input  logic                                 cfg_valid,
   input  logic [PLL_SEL_W-1:0]                 cfg_idsel,
   input  logic [PLL_SEL_W-1:0]                 cfg_fbdsel,
   input  logic [PLL_SEL_W-1:0]                 cfg_odsel,
   output logic                                 cfg_ready,
   output logic                                 clk_ok,
   output logic                                 user_rst_n,
   output logic                                 fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
   ,
   output logic [15:0]                          loss_cnt
`endif
);

   localparam int unsigned CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

   pll_sup_state_e              state, state_nxt;
   logic [CNT_W-1:0]            cnt, cnt_nxt, cnt_inc;
   logic [RETRY_W-1:0]          retry_nxt;
   logic [PLL_SEL_W-1:0]        idsel_nxt, fbdsel_nxt, odsel_nxt;
   logic                        lock_s;
   logic                        accept;
   logic                        fail;
`ifdef PLL_SUP_LOSS_CNT_EN
   logic                        loss_evt;
`endif

   sync_2ff u_lock_sync (
      .clk   (clkin),
      .clr_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   assign accept  = cfg_valid & cfg_ready;
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      retry_nxt  = retry_cnt;
      idsel_nxt  = pll_idsel;
      fbdsel_nxt = pll_fbdsel;
      odsel_nxt  = pll_odsel;
      fail       = 1'b0;
`ifdef PLL_SUP_LOSS_CNT_EN
      loss_evt   = 1'b0;
`endif
      case (state)
         RST_HOLD: begin
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
               fail = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               fail = 1'b1;
            end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
               state_nxt = LOCKED;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         LOCKED: begin
            // An accepted config wins over a simultaneous lock drop; both
            // land in RST_HOLD, only the select/retry side effects differ.
            if (!accept && !lock_s) begin
               state_nxt = RST_HOLD;
               cnt_nxt   = '0;
`ifdef PLL_SUP_LOSS_CNT_EN
               loss_evt  = 1'b1;
`endif
            end
         end
         FAULT: ;
         default: begin
            state_nxt = RST_HOLD;
            cnt_nxt   = '0;
         end
      endcase

      if (fail) begin
         retry_nxt = retry_cnt + RETRY_W'(1);
         state_nxt = (retry_nxt == RETRY_W'(MAX_RETRIES)) ? FAULT : RST_HOLD;
         cnt_nxt   = '0;
      end

      // cfg_ready is only high in LOCKED/FAULT, so accept implies one of those.
      if (accept) begin
         state_nxt  = RST_HOLD;
         cnt_nxt    = '0;
         retry_nxt  = '0;
         idsel_nxt  = cfg_idsel;
         fbdsel_nxt = cfg_fbdsel;
         odsel_nxt  = cfg_odsel;
      end
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state      <= RST_HOLD;
         cnt        <= '0;
         retry_cnt  <= '0;
         pll_idsel  <= DFLT_IDSEL;
         pll_fbdsel <= DFLT_FBDSEL;
         pll_odsel  <= DFLT_ODSEL;
         pll_reset  <= 1'b1;
         cfg_ready  <= 1'b0;
         clk_ok     <= 1'b0;
         user_rst_n <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         retry_cnt  <= retry_nxt;
         pll_idsel  <= idsel_nxt;
         pll_fbdsel <= fbdsel_nxt;
         pll_odsel  <= odsel_nxt;
         pll_reset  <= (state_nxt == RST_HOLD) || (state_nxt == FAULT);
         cfg_ready  <= (state_nxt == LOCKED) || (state_nxt == FAULT);
         clk_ok     <= (state_nxt == LOCKED);
         user_rst_n <= clk_ok;
         fault      <= (state_nxt == FAULT);
      end
   end

`ifdef PLL_SUP_LOSS_CNT_EN
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         loss_cnt <= '0;
      end else if (loss_evt && (loss_cnt != '1)) begin
         loss_cnt <= loss_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed bench for pll_lock_supervisor with
// RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.
// Expected values are queued as stimulus is applied and popped as outputs
// are sampled (1 time unit after each rising edge).
// Optional macro: PLL_SUP_LOSS_CNT_EN (adds loss_cnt checks).
module tb_pll_lock_supervisor;

   logic       clkin = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       pll_reset;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic       cfg_valid;
   logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
   logic       cfg_ready;
   logic       clk_ok;
   logic       user_rst_n;
   logic       fault;
   logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
   logic [15:0] loss_cnt;
`endif

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   pll_lock_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (3),
      .DFLT_IDSEL    (6'd0),
      .DFLT_FBDSEL   (6'd0),
      .DFLT_ODSEL    (6'd0)
   ) dut (
      .clkin      (clkin),
      .rst_n      (rst_n),
      .pll_lock   (pll_lock),
      .pll_reset  (pll_reset),
      .pll_idsel  (pll_idsel),
      .pll_fbdsel (pll_fbdsel),
      .pll_odsel  (pll_odsel),
      .cfg_valid  (cfg_valid),
      .cfg_idsel  (cfg_idsel),
      .cfg_fbdsel (cfg_fbdsel),
      .cfg_odsel  (cfg_odsel),
      .cfg_ready  (cfg_ready),
      .clk_ok     (clk_ok),
      .user_rst_n (user_rst_n),
      .fault      (fault),
      .retry_cnt  (retry_cnt)
`ifdef PLL_SUP_LOSS_CNT_EN
      ,
      .loss_cnt   (loss_cnt)
`endif
   );

   always #5 clkin = ~clkin;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] val);
      sb.push_back('{tag, val});
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL %s: observed=%0d expected=<nothing queued>", tag, obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val && tag == e.tag) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d (queued as %s)", tag, obs, e.val, e.tag);
      end
   endtask

   task automatic wait_clk_ok(input int budget);
      int n;
      n = 0;
      while (clk_ok !== 1'b1 && n < budget) begin
         step(1);
         n++;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
   endtask

   initial begin
      int first_ok, first_urst, n;

      rst_n     = 1'b0;
      pll_lock  = 1'b0;
      cfg_valid = 1'b0;
      cfg_idsel = '0;
      cfg_fbdsel = '0;
      cfg_odsel = '0;
      step(3);

      // Reset values
      expect_val("rst_pll_reset", 1);
      expect_val("rst_clk_ok", 0);
      expect_val("rst_user_rst_n", 0);
      expect_val("rst_fault", 0);
      expect_val("rst_retry_cnt", 0);
      expect_val("rst_cfg_ready", 0);
      expect_val("rst_idsel", 0);
      expect_val("rst_fbdsel", 0);
      expect_val("rst_odsel", 0);
      check("rst_pll_reset", pll_reset);
      check("rst_clk_ok", clk_ok);
      check("rst_user_rst_n", user_rst_n);
      check("rst_fault", fault);
      check("rst_retry_cnt", retry_cnt);
      check("rst_cfg_ready", cfg_ready);
      check("rst_idsel", pll_idsel);
      check("rst_fbdsel", pll_fbdsel);
      check("rst_odsel", pll_odsel);

      // Normal bring-up: lock rises from cycle 6; cycle c = sample after edge c-1
      rst_n = 1'b1;
      first_ok = -1;
      first_urst = -1;
      for (int e = 0; e < 40; e++) begin
         step(1);
         if (e == 2) begin
            expect_val("bringup_reset_cyc3", 1);
            check("bringup_reset_cyc3", pll_reset);
         end
         if (e == 3) begin
            expect_val("bringup_reset_cyc4", 0);
            check("bringup_reset_cyc4", pll_reset);
         end
         if (e == 5) pll_lock = 1'b1;
         if (clk_ok === 1'b1 && first_ok < 0) first_ok = e + 1;
         if (user_rst_n === 1'b1 && first_urst < 0) first_urst = e + 1;
      end
      expect_val("bringup_clk_ok_cycle", 17);
      check("bringup_clk_ok_cycle", first_ok);
      expect_val("bringup_user_rst_cycle", 18);
      check("bringup_user_rst_cycle", first_urst);
      expect_val("locked_cfg_ready", 1);
      check("locked_cfg_ready", cfg_ready);
      expect_val("locked_retry_cnt", 0);
      check("locked_retry_cnt", retry_cnt);

      // Lock loss in LOCKED
      pll_lock = 1'b0;
      step(3);
      expect_val("loss_clk_ok", 0);
      check("loss_clk_ok", clk_ok);
      expect_val("loss_pll_reset", 1);
      check("loss_pll_reset", pll_reset);
      pll_lock = 1'b1;
      n = 1;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (pll_reset !== 1'b1) break;
         n++;
      end
      expect_val("loss_reset_pulse_len", 4);
      check("loss_reset_pulse_len", n);
      expect_val("loss_retry_cnt", 0);
      check("loss_retry_cnt", retry_cnt);
      expect_val("loss_user_rst_n", 0);
      check("loss_user_rst_n", user_rst_n);
`ifdef PLL_SUP_LOSS_CNT_EN
      expect_val("loss_cnt", 1);
      check("loss_cnt", loss_cnt);
`endif
      wait_clk_ok(60);
      expect_val("relock_clk_ok", 1);
      check("relock_clk_ok", clk_ok);

      // Reconfig from LOCKED
      expect_val("cfg_ready_before", 1);
      check("cfg_ready_before", cfg_ready);
      cfg_valid = 1'b1;
      cfg_idsel = 6'd5;
      cfg_fbdsel = 6'd9;
      cfg_odsel = 6'd2;
      step(1);
      cfg_valid = 1'b0;
      expect_val("cfg_idsel", 5);
      expect_val("cfg_fbdsel", 9);
      expect_val("cfg_odsel", 2);
      expect_val("cfg_pll_reset", 1);
      expect_val("cfg_clk_ok", 0);
      expect_val("cfg_ready_after", 0);
      check("cfg_idsel", pll_idsel);
      check("cfg_fbdsel", pll_fbdsel);
      check("cfg_odsel", pll_odsel);
      check("cfg_pll_reset", pll_reset);
      check("cfg_clk_ok", clk_ok);
      check("cfg_ready_after", cfg_ready);
      step(1);
      expect_val("cfg_user_rst_n", 0);
      check("cfg_user_rst_n", user_rst_n);
      wait_clk_ok(60);
      expect_val("cfg_requalified", 1);
      check("cfg_requalified", clk_ok);
      expect_val("cfg_idsel_kept", 5);
      check("cfg_idsel_kept", pll_idsel);

      // Glitch in STABLE: lock high 5 cycles, low 1, then clean
      pll_lock = 1'b0;
      pulse_reset();
      expect_val("rst_locked_idsel", 0);
      check("rst_locked_idsel", pll_idsel);
      for (int e = 0; e < 14; e++) begin
         step(1);
         if (e == 5)  pll_lock = 1'b1;
         if (e == 10) pll_lock = 1'b0;
         if (e == 11) pll_lock = 1'b1;
         if (e == 12) begin
            expect_val("glitch_retry_before", 0);
            check("glitch_retry_before", retry_cnt);
         end
         if (e == 13) begin
            expect_val("glitch_retry_cnt", 1);
            check("glitch_retry_cnt", retry_cnt);
            expect_val("glitch_pll_reset", 1);
            check("glitch_pll_reset", pll_reset);
         end
      end
      wait_clk_ok(60);
      expect_val("glitch_relock", 1);
      check("glitch_relock", clk_ok);
      expect_val("glitch_retry_cleared", 0);
      check("glitch_retry_cleared", retry_cnt);

      // Timeouts: lock held low -> three 24-cycle attempts, then FAULT
      pll_lock = 1'b0;
      pulse_reset();
      for (int e = 0; e < 80; e++) begin
         step(1);
         if (e == 22) begin
            expect_val("to_retry_0", 0);
            check("to_retry_0", retry_cnt);
         end
         if (e == 23) begin
            expect_val("to_retry_1", 1);
            check("to_retry_1", retry_cnt);
         end
         if (e == 47) begin
            expect_val("to_retry_2", 2);
            check("to_retry_2", retry_cnt);
         end
         if (e == 70) begin
            expect_val("to_fault_before", 0);
            check("to_fault_before", fault);
         end
         if (e == 71) begin
            expect_val("to_fault", 1);
            expect_val("to_retry_3", 3);
            expect_val("to_fault_pll_reset", 1);
            expect_val("to_fault_cfg_ready", 1);
            check("to_fault", fault);
            check("to_retry_3", retry_cnt);
            check("to_fault_pll_reset", pll_reset);
            check("to_fault_cfg_ready", cfg_ready);
         end
      end
      expect_val("to_fault_held", 1);
      check("to_fault_held", fault);

      // Config accepted in FAULT
      cfg_valid = 1'b1;
      cfg_idsel = 6'd1;
      cfg_fbdsel = 6'd2;
      cfg_odsel = 6'd3;
      step(1);
      cfg_valid = 1'b0;
      expect_val("fcfg_fault", 0);
      expect_val("fcfg_retry", 0);
      expect_val("fcfg_idsel", 1);
      expect_val("fcfg_fbdsel", 2);
      expect_val("fcfg_odsel", 3);
      expect_val("fcfg_pll_reset", 1);
      check("fcfg_fault", fault);
      check("fcfg_retry", retry_cnt);
      check("fcfg_idsel", pll_idsel);
      check("fcfg_fbdsel", pll_fbdsel);
      check("fcfg_odsel", pll_odsel);
      check("fcfg_pll_reset", pll_reset);

      // Reset mid-WAIT_LOCK
      step(6);
      expect_val("wl_in_wait", 0);
      check("wl_in_wait", pll_reset);
      pulse_reset();
      expect_val("wl_rst_idsel", 0);
      expect_val("wl_rst_fbdsel", 0);
      expect_val("wl_rst_odsel", 0);
      expect_val("wl_rst_pll_reset", 1);
      expect_val("wl_rst_fault", 0);
      check("wl_rst_idsel", pll_idsel);
      check("wl_rst_fbdsel", pll_fbdsel);
      check("wl_rst_odsel", pll_odsel);
      check("wl_rst_pll_reset", pll_reset);
      check("wl_rst_fault", fault);

      // Reset while in FAULT
      n = 0;
      while (fault !== 1'b1 && n < 100) begin
         step(1);
         n++;
      end
      expect_val("refault", 1);
      check("refault", fault);
      pulse_reset();
      expect_val("frst_fault", 0);
      expect_val("frst_retry", 0);
      expect_val("frst_pll_reset", 1);
      expect_val("frst_cfg_ready", 0);
      expect_val("frst_clk_ok", 0);
      expect_val("frst_user_rst_n", 0);
      check("frst_fault", fault);
      check("frst_retry", retry_cnt);
      check("frst_pll_reset", pll_reset);
      check("frst_cfg_ready", cfg_ready);
      check("frst_clk_ok", clk_ok);
      check("frst_user_rst_n", user_rst_n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the Gowin rPLL from a free-running input clock: reset pulse, lock wait with timeout, lock-stability qualification, lock-loss recovery, and bounded retries.
- Drives the PLL dynamic divider selects (IDSEL/FBDSEL/ODSEL) from a request/acknowledge config port.
- Produces a qualified clock-good flag and a downstream synchronous reset for logic in the PLL output domain.
- Sits between the board oscillator/reset and the PLL wrapper instance.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per attempt (≥1).
- LOCK_TIMEOUT, 100000: cycles to wait for synchronized lock before the attempt fails.
- STABLE_CYCLES, 1024: consecutive lock-high cycles required before clk_ok.
- MAX_RETRIES, 3: failed attempts allowed before FAULT (≥1).
- DFLT_IDSEL / DFLT_FBDSEL / DFLT_ODSEL, 6'd0: divider selects loaded at reset.

Ports:
- clkin  in  1  free-running reference clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pll_lock  in  1  raw PLL LOCK; asynchronous, so it passes through a 2-FF synchronizer.
- pll_reset  out  1  PLL RESET, active high.
- pll_idsel  out  6  IDSEL to the PLL.
- pll_fbdsel  out  6  FBDSEL to the PLL.
- pll_odsel  out  6  ODSEL to the PLL.
- cfg_valid  in  1  new divider set requested.
- cfg_idsel / cfg_fbdsel / cfg_odsel  in  6 each  requested selects; passed through raw, encoding is the caller's.
- cfg_ready  out  1  config accepted this cycle when cfg_valid & cfg_ready.
- clk_ok  out  1  PLL locked and qualified.
- user_rst_n  out  1  downstream reset, active low; equals clk_ok registered once.
- fault  out  1  retries exhausted.
- retry_cnt  out  clog2(MAX_RETRIES+1)  failed attempts since the last successful lock or accepted config.

Behaviour:
- Reset (rst_n=0):
  - Outputs: pll_reset=1, selects=DFLT_*, cfg_ready=0, clk_ok=0, user_rst_n=0, fault=0, retry_cnt=0.
  - State=RST_HOLD, counter=0, synchronizer flops cleared.
- States:
  - RST_HOLD: pll_reset=1; counter counts to RST_CYCLES-1, then WAIT_LOCK with counter cleared.
  - WAIT_LOCK: pll_reset=0.
    - lock_s=1 → STABLE, counter cleared.
    - Counter reaching LOCK_TIMEOUT-1 → attempt failed.
  - STABLE:
    - lock_s=0 → attempt failed.
    - STABLE_CYCLES consecutive highs → LOCKED; retry_cnt cleared.
  - LOCKED: clk_ok=1.
    - lock_s=0 → RST_HOLD, clk_ok=0 the next cycle, retry_cnt unchanged. Lock loss is not counted as a failure.
  - FAULT: pll_reset=1, fault=1; exits only on an accepted config or on reset.
- Attempt failed: retry_cnt+1. If the new value equals MAX_RETRIES → FAULT, otherwise → RST_HOLD.
- Config handshake:
  - cfg_ready=1 only in LOCKED and FAULT.
  - On accept: latch the three selects (visible on pll_*sel the next cycle); clear retry_cnt, fault and clk_ok; go to RST_HOLD.
  - cfg_valid is ignored in other states and is not queued. The requester holds it until ready.
- Priority when lock drops and cfg is accepted in the same cycle in LOCKED: the config is accepted; the result is RST_HOLD either way.
- Selects change only while pll_reset=1 (the accept cycle is followed by RST_HOLD).
- Latency:
  - Raw lock to lock_s: 2 cycles.
  - Earliest clk_ok after rst_n release: RST_CYCLES + 2 + STABLE_CYCLES + 1.
  - user_rst_n rises 1 cycle after clk_ok and falls 1 cycle after clk_ok falls.
- Counter width: clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)). Saturating; never wraps.

Optional Feature:
- Macro: PLL_SUP_LOSS_CNT_EN.
- Defined:
  - Adds output loss_cnt [15:0], counting LOCKED→RST_HOLD transitions caused by lock loss.
  - Saturates at 16'hFFFF. Cleared only by rst_n; not cleared by config accept.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package pll_sup_pkg:
  - State enum (RST_HOLD, WAIT_LOCK, STABLE, LOCKED, FAULT).
  - Select width constant PLL_SEL_W=6.
- One sub-module, sync_2ff: generic 2-flop bit synchronizer for pll_lock with synchronous active-low clear. Reusable elsewhere.

Test Plan (bench params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3):
- Normal bring-up: release rst_n; pll_lock=1 from cycle 6 → pll_reset high cycles 0–3; clk_ok rises cycle 6+2+8+1=17 (±1 as specified); user_rst_n one cycle later.
- Timeouts: pll_lock held 0 → three attempts of 4+20 cycles; retry_cnt 1,2,3; fault=1, pll_reset=1, cfg_ready=1 thereafter.
- Glitch in STABLE: lock high 5 cycles, low 1 → retry_cnt=1, RST_HOLD re-entered; next clean lock → clk_ok=1, retry_cnt=0.
- Lock loss in LOCKED: drop pll_lock → clk_ok=0 within 3 cycles, pll_reset pulses 4 cycles, retry_cnt stays 0; loss_cnt=1 when the macro is defined.
- Reconfig: in LOCKED, cfg_valid with idsel=5, fbdsel=9, odsel=2 → cfg_ready handshake completes; selects update the next cycle while pll_reset=1; clk_ok=0 until requalified.
- Reset mid-WAIT_LOCK and in FAULT: drop rst_n for 1 cycle → all outputs at reset values, selects back to DFLT_*, fault=0.
